// File: rtl/apb_master_bridge.sv
// Bridges a single-request data bus to an APB peripheral bus: address decode to NUM_SLV slaves,
// SETUP/ACCESS sequencing with wait states, slave-error and timeout reporting.
module apb_master_bridge #(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned SLV_AW    = 12,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  slverr,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int unsigned IDX_W  = $clog2(NUM_SLV);
  localparam int unsigned HI_LSB = SLV_AW + IDX_W;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [31:0]        paddr_q,   paddr_d;
  logic               pwrite_q,  pwrite_d;
  logic [31:0]        pwdata_q,  pwdata_d;
  logic               penable_q, penable_d;
  logic [NUM_SLV-1:0] psel_q,    psel_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               ready_q,   ready_d;
  logic               slverr_q,  slverr_d;
  logic [31:0]        rdata_q,   rdata_d;

  logic               hit_c;
  logic [IDX_W-1:0]   req_idx_c;
  logic [31:0]        sel_rdata_c;
  logic               sel_ready_c;
  logic               sel_err_c;

  // Window decode on the bits above the per-slave index field
  assign hit_c       = (addr >> HI_LSB) == (BASE_ADDR >> HI_LSB);
  assign req_idx_c   = addr[SLV_AW +: IDX_W];
  assign sel_rdata_c = PRDATA[{idx_q, 5'b0} +: 32];
  assign sel_ready_c = PREADY[idx_q];
  assign sel_err_c   = PSLVERR[idx_q];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      slverr_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      slverr_q  <= slverr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and registered-output logic; ready/slverr default low so they pulse
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    slverr_d  = 1'b0;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (transfer && !ready_q) begin
          if (hit_c) begin
            paddr_d  = addr;
            pwrite_d = write;
            pwdata_d = wdata;
            idx_d    = req_idx_c;
            psel_d   = NUM_SLV'(1) << req_idx_c;
            state_d  = S_SETUP;
          end else begin
            ready_d  = 1'b1;
            slverr_d = 1'b1;
            rdata_d  = '0;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready_c) begin
          ready_d   = 1'b1;
          slverr_d  = sel_err_c;
          rdata_d   = (!pwrite_q && !sel_err_c) ? sel_rdata_c : 32'h0;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ready_d   = 1'b1;
          slverr_d  = 1'b1;
          rdata_d   = '0;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign slverr  = slverr_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;

endmodule
